uart_link_xcvr: RTL and testbench

- Full-duplex, parametrised serial link endpoint for the Master/Slave board connection.
- Generalises the fixed 16-bit strobe-framed send/receive pair with:
  - configurable word width and bit period;
  - optional parity;
  - valid/ready handshakes on both sides;
  - an RX buffer FIFO;
  - error reporting.
- Sits between game logic (attack/board words) and the inter-board wires. One instance per board.

---
 rtl/uart_link_pkg.sv | 23 ++
 rtl/uart_link_xcvr_sync_fifo.sv | 79 +++++++
 rtl/uart_link_xcvr.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_link_xcvr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the inter-board serial link endpoint.
package uart_link_pkg;

    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_WAIT_LOW
    } rx_state_t;

    // Payloads narrower than PAR_MAX_W are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] payload, input logic odd);
        return (^payload) ^ odd;
    endfunction

endpackage

// File: rtl/uart_link_xcvr_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; simultaneous push and pop allowed when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = cnt_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/uart_link_xcvr.sv
// Full-duplex strobe-framed serial link endpoint: parity-protected TX/RX with an RX FIFO
// and one-cycle error pulses for parity, framing and overflow faults.
module uart_link_xcvr
    import uart_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BIT_CYCLES = 100,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned RX_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        sig_out,
    output logic                        data_out,
    input  logic                        sig_in,
    input  logic                        data_in,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_par_err,
    output logic                        rx_frm_err,
    output logic                        rx_ovf
);

    localparam int unsigned NB    = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int unsigned BIT_W = $clog2(NB);
    localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_MID  = CYC_W'(BIT_CYCLES / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    // ---------------- transmitter ----------------
    tx_state_t         tx_state_q, tx_state_d;
    logic [CYC_W-1:0]  tx_cyc_q, tx_cyc_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [NB-1:0]     tx_frame_q, tx_frame_d;
    logic [NB-1:0]     tx_frame_c;
    logic              sig_out_q, sig_out_d;
    logic              data_out_q, data_out_d;
    logic              tx_ready_q, tx_ready_d;

    always_comb begin
        tx_frame_c = NB'(tx_data);
        if (PARITY_EN != 0) begin
            tx_frame_c[NB-1] = parity_bit(PAR_MAX_W'(tx_data), ODD);
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cyc_d   = tx_cyc_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        sig_out_d  = sig_out_q;
        data_out_d = data_out_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_state_d = TX_SEND;
                    tx_frame_d = tx_frame_c;
                    tx_cyc_d   = '0;
                    tx_bit_d   = '0;
                    sig_out_d  = 1'b1;
                    data_out_d = tx_frame_c[0];
                    tx_ready_d = 1'b0;
                end
            end
            TX_SEND: begin
                if (tx_cyc_q == CYC_LAST) begin
                    tx_cyc_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = TX_GAP;
                        sig_out_d  = 1'b0;
                        data_out_d = 1'b0;
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        data_out_d = tx_frame_q[tx_bit_q + BIT_W'(1)];
                    end
                end else begin
                    tx_cyc_d = tx_cyc_q + CYC_W'(1);
                end
            end
            TX_GAP: begin
                if (tx_cyc_q == CYC_LAST) begin
                    tx_cyc_d   = '0;
                    tx_state_d = TX_IDLE;
                    tx_ready_d = 1'b1;
                end else begin
                    tx_cyc_d = tx_cyc_q + CYC_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tx_state_q <= TX_IDLE;
            tx_cyc_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '0;
            sig_out_q  <= 1'b0;
            data_out_q <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cyc_q   <= tx_cyc_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
            sig_out_q  <= sig_out_d;
            data_out_q <= data_out_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign sig_out  = sig_out_q;
    assign data_out = data_out_q;

    // ---------------- receiver ----------------
    logic sig_s1_q, sig_s1_d, sig_s2_q, sig_s2_d, sig_prev_q, sig_prev_d;
    logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;

    rx_state_t         rx_state_q, rx_state_d;
    logic [CYC_W-1:0]  rx_cyc_q, rx_cyc_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [NB-2:0]     rx_shift_q, rx_shift_d;
    logic [NB-1:0]     rx_frame_c;
    logic              rx_par_ok_c;
    logic              push_c;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              ovf_q, ovf_d;
    logic              fifo_full, fifo_empty;

    always_comb begin
        sig_s1_d   = sig_in;
        sig_s2_d   = sig_s1_q;
        sig_prev_d = sig_s2_q;
        dat_s1_d   = data_in;
        dat_s2_d   = dat_s1_q;
    end

    // Frame as it stands if the current synchronised bit were the last sample.
    always_comb begin
        rx_frame_c  = {dat_s2_q, rx_shift_q};
        rx_par_ok_c = (PARITY_EN == 0) ||
                      (rx_frame_c[NB-1] == parity_bit(PAR_MAX_W'(rx_frame_c[DATA_W-1:0]), ODD));
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cyc_d   = rx_cyc_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_c     = 1'b0;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        ovf_d      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (sig_s2_q && !sig_prev_q) begin
                    rx_state_d = RX_RECV;
                    rx_cyc_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RX_RECV: begin
                if (rx_cyc_q == CYC_LAST) begin
                    rx_cyc_d = '0;
                    rx_bit_d = rx_bit_q + BIT_W'(1);
                end else begin
                    rx_cyc_d = rx_cyc_q + CYC_W'(1);
                end
                if (rx_cyc_q == CYC_MID) begin
                    if (!sig_s2_q) begin
                        frm_err_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_shift_d = rx_frame_c[NB-1:1];
                        if (rx_bit_q == BIT_LAST) begin
                            rx_state_d = RX_WAIT_LOW;
                            if (!rx_par_ok_c) begin
                                par_err_d = 1'b1;
                            end else if (fifo_full && !rx_ready) begin
                                ovf_d = 1'b1;
                            end else begin
                                push_c = 1'b1;
                            end
                        end
                    end
                end
            end
            RX_WAIT_LOW: begin
                if (!sig_s2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sig_s1_q   <= 1'b0;
            sig_s2_q   <= 1'b0;
            sig_prev_q <= 1'b0;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_cyc_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sig_s1_q   <= sig_s1_d;
            sig_s2_q   <= sig_s2_d;
            sig_prev_q <= sig_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            rx_state_q <= rx_state_d;
            rx_cyc_q   <= rx_cyc_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rx_par_err = par_err_q;
    assign rx_frm_err = frm_err_q;
    assign rx_ovf     = ovf_q;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push_c),
        .push_data (rx_frame_c[DATA_W-1:0]),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .count     (rx_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_link_xcvr.sv
// Loopback/injection bench for uart_link_xcvr with a queue scoreboard on the RX side.
module tb_uart_link_xcvr;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BC     = 4;
    localparam int unsigned NB     = 17;
    localparam int unsigned CNT_W  = 3;

    logic              clk = 1'b0;
    logic              clr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sig_out, data_out;
    logic              sig_in, data_in;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [CNT_W-1:0]  rx_count;
    logic              rx_par_err, rx_frm_err, rx_ovf;
    logic              loop_en, inj_sig, inj_data;

    always #5 clk = ~clk;

    assign sig_in  = loop_en ? sig_out  : inj_sig;
    assign data_in = loop_en ? data_out : inj_data;

    uart_link_xcvr #(
        .DATA_W     (DATA_W),
        .BIT_CYCLES (BC),
        .PARITY_EN  (1),
        .PARITY_ODD (0),
        .RX_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sig_out    (sig_out),
        .data_out   (data_out),
        .sig_in     (sig_in),
        .data_in    (data_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_count   (rx_count),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err),
        .rx_ovf     (rx_ovf)
    );

    int errors = 0;
    int checks = 0;
    int par_seen = 0, frm_seen = 0, ovf_seen = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every consumed RX word must match the oldest expected word.
    always @(negedge clk) begin
        if (!clr) begin
            if (rx_par_err) par_seen++;
            if (rx_frm_err) frm_seen++;
            if (rx_ovf)     ovf_seen++;
            if (rx_valid && rx_ready) begin
                check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_val("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns one step after the accepting edge.
    task automatic send_word(input logic [DATA_W-1:0] w);
        int guard = 0;
        @(negedge clk);
        while (!tx_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check_val("tx_ready_wait", 32'(tx_ready), 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = DATA_W'($urandom);
    endtask

    task automatic send_watch(input logic [DATA_W-1:0] w);
        logic [NB-1:0] wire_bits = '0;
        int hi = 0;
        send_word(w);
        for (int c = 1; c <= 73; c++) begin
            @(negedge clk);
            if (sig_out) hi++;
            if (c >= 2 && ((c - 2) % BC) == 0 && ((c - 2) / BC) < NB) wire_bits[(c - 2) / BC] = data_out;
            if (c == 1)  check_val("tx_ready_busy", 32'(tx_ready), 32'd0);
            if (c == 68) check_val("sig_last_hi",   32'(sig_out),  32'd1);
            if (c == 69) check_val("sig_gap_lo",    32'(sig_out),  32'd0);
            if (c == 72) check_val("tx_ready_gap",  32'(tx_ready), 32'd0);
            if (c == 73) check_val("tx_ready_back", 32'(tx_ready), 32'd1);
        end
        check_val("sig_hi_cycles", 32'(hi), 32'd68);
        check_val("wire_payload",  32'(wire_bits[DATA_W-1:0]), 32'(w));
        check_val("wire_parity",   32'(wire_bits[NB-1]), 32'(^w));
    endtask

    // Drives a frame on the RX wires directly; sig drops at drop_bit (negative = full frame).
    task automatic inject(input logic [NB-1:0] frame, input int drop_bit);
        loop_en = 1'b0;
        for (int k = 0; k < NB && k != drop_bit; k++) begin
            inj_sig  = 1'b1;
            inj_data = frame[k];
            repeat (BC) @(posedge clk);
            #1;
        end
        inj_sig  = 1'b0;
        inj_data = 1'b0;
        tick(12);
        loop_en = 1'b1;
    endtask

    task automatic drain();
        int guard = 0;
        rx_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 600) begin
            tick(1);
            guard++;
        end
        rx_ready = 1'b0;
        check_val("drain_done", 32'(exp_q.size()), 32'd0);
        check_val("drain_empty", 32'(rx_count), 32'd0);
    endtask

    task automatic wait_count(input int n);
        int guard = 0;
        while (rx_count != CNT_W'(n) && guard < 600) begin
            tick(1);
            guard++;
        end
        check_val("wait_count", 32'(rx_count), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] w;
        int p0, f0, o0;

        clr = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        loop_en = 1'b1; inj_sig = 1'b0; inj_data = 1'b0;
        tick(3);
        check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_val("rst_sig_out",  32'(sig_out),  32'd0);
        check_val("rst_data_out", 32'(data_out), 32'd0);
        check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_val("rst_rx_count", 32'(rx_count), 32'd0);
        check_val("rst_pulses",   32'({rx_par_err, rx_frm_err, rx_ovf}), 32'd0);
        clr = 1'b0;
        tick(2);

        // Basic loopback with wire-level frame check.
        exp_q.push_back(16'hA5C3);
        send_watch(16'hA5C3);
        drain();

        // Odd-weight payload, then the same frame with its parity bit flipped.
        w = 16'h0001;
        exp_q.push_back(w);
        send_watch(w);
        drain();
        p0 = par_seen;
        inject({~(^w), w}, -1);
        check_val("par_err_pulse", 32'(par_seen - p0), 32'd1);
        check_val("par_no_push",   32'(rx_count), 32'd0);

        // Five words into a four-entry FIFO with no consumer.
        o0 = ovf_seen;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(DATA_W'(i));
            send_word(DATA_W'(i));
        end
        tick(90);
        check_val("ovf_count_full", 32'(rx_count), 32'd4);
        check_val("ovf_pulse",      32'(ovf_seen - o0), 32'd1);
        drain();

        // Full FIFO, final frame lands in the same cycle as a pop.
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(DATA_W'(i));
            send_word(DATA_W'(i));
        end
        wait_count(4);
        o0 = ovf_seen;
        exp_q.push_back(16'h0005);
        send_word(16'h0005);
        tick(69);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(3);
        check_val("full_pop_no_ovf", 32'(ovf_seen - o0), 32'd0);
        check_val("full_pop_count",  32'(rx_count), 32'd4);
        check_val("full_pop_order",  32'(exp_q.size()), 32'd4);
        drain();

        // Strobe dropped at bit 6, then a clean frame.
        w = 16'h1234;
        f0 = frm_seen;
        inject({^w, w}, 6);
        check_val("frm_err_pulse", 32'(frm_seen - f0), 32'd1);
        check_val("frm_no_push",   32'(rx_count), 32'd0);
        exp_q.push_back(w);
        inject({^w, w}, -1);
        drain();

        // Reset in the middle of a transfer with a word already buffered.
        exp_q.push_back(16'h0042);
        send_word(16'h0042);
        wait_count(1);
        f0 = frm_seen; p0 = par_seen; o0 = ovf_seen;
        send_word(16'h5A5A);
        tick(33);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        exp_q.delete();
        check_val("clr_sig_out",  32'(sig_out),  32'd0);
        check_val("clr_tx_ready", 32'(tx_ready), 32'd1);
        check_val("clr_rx_count", 32'(rx_count), 32'd0);
        check_val("clr_rx_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(16'hBEEF);
        send_word(16'hBEEF);
        tick(80);
        check_val("clr_no_errors", 32'((frm_seen - f0) + (par_seen - p0) + (ovf_seen - o0)), 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
